// File: rtl/router_pkg.sv
// Shared definitions for the router register stage: integrity-check encodings
// and header field extraction helpers.
package router_pkg;

    localparam int unsigned CHK_XOR   = 0;
    localparam int unsigned CHK_SUM   = 1;

    // Helpers operate on a 32-bit carrier; callers zero-extend and truncate.
    localparam int unsigned HDR_MAX_W = 32;

    // Destination field: header bits [addr_w-1:0].
    function automatic logic [HDR_MAX_W-1:0] hdr_addr_field(
        input logic [HDR_MAX_W-1:0] hdr,
        input int unsigned          addr_w
    );
        return hdr & ((HDR_MAX_W'(1) << addr_w) - HDR_MAX_W'(1));
    endfunction

    // Length field: header bits above the destination field.
    function automatic logic [HDR_MAX_W-1:0] hdr_len_field(
        input logic [HDR_MAX_W-1:0] hdr,
        input int unsigned          addr_w
    );
        return hdr >> addr_w;
    endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Integrity accumulator, payload counter and check-byte capture, with the
// combinational compares used by the top level at check time.
module router_chk_acc
    import router_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned CHK_MODE = CHK_XOR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     fold_hdr,
    input  logic                     fold_pay,
    input  logic                     load_chk,
    input  logic [DATA_W-1:0]        hold_hdr,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [DATA_W-ADDR_W-1:0] len_field,
    output logic                     acc_match,
    output logic                     len_match
);

    localparam int unsigned LEN_W = DATA_W - ADDR_W;
    localparam int unsigned PCW   = LEN_W + 1;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] pkt_chk;
    logic [PCW-1:0]    pay_cnt;

    // One step of the selected integrity function.
    function automatic logic [DATA_W-1:0] fold(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        if (CHK_MODE == CHK_SUM) return a + b;
        else                     return a ^ b;
    endfunction

    // Accumulator and payload count: cleared by a valid header, header folded
    // in lfd, each accepted payload byte folded and counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            pay_cnt <= '0;
        end else if (clr) begin
            acc     <= '0;
            pay_cnt <= '0;
        end else if (fold_hdr) begin
            acc     <= fold(acc, hold_hdr);
        end else if (fold_pay) begin
            acc     <= fold(acc, data_in);
            pay_cnt <= pay_cnt + PCW'(1);
        end
    end

    // Check byte capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pkt_chk <= '0;
        else if (load_chk) pkt_chk <= data_in;
    end

    assign acc_match = (acc == pkt_chk);
    assign len_match = (pay_cnt == {1'b0, len_field});

endmodule

// File: rtl/router_regi_param.sv
// Parametrised router register stage: header hold, full-byte capture, data
// stream to the FIFOs, end-of-packet flags, integrity/length check results
// and a saturating bad-packet counter. DATA_W is limited to 32.
module router_regi_param
    import router_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned NUM_DEST = 3,
    parameter int unsigned CHK_MODE = CHK_XOR,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              rst_int_reg,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] hdr_addr,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              len_err,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int unsigned LEN_W = DATA_W - ADDR_W;

    logic [DATA_W-1:0] hold_hdr;
    logic [DATA_W-1:0] full_byte;
    logic              checked;
    logic              hdr_valid;
    logic              pay_fold;
    logic              chk_load;
    logic              pd_set;
    logic [LEN_W-1:0]  len_field;
    logic              acc_match;
    logic              len_match;

    // A header is accepted only when its destination exists.
    assign hdr_valid = detect_add & pkt_valid &
                       (hdr_addr_field(HDR_MAX_W'(data_in), ADDR_W) < HDR_MAX_W'(NUM_DEST));
    assign len_field = LEN_W'(hdr_len_field(HDR_MAX_W'(hold_hdr), ADDR_W));
    assign pay_fold  = ld_state & pkt_valid & ~full_state;
    assign chk_load  = ld_state & ~pkt_valid;
    assign pd_set    = (ld_state & ~fifo_full & ~pkt_valid) |
                       (laf_state & low_pkt_valid & ~parity_done);

    // Header and destination latch.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hold_hdr <= '0;
            hdr_addr <= '0;
        end else if (hdr_valid) begin
            hold_hdr <= data_in;
            hdr_addr <= ADDR_W'(hdr_addr_field(HDR_MAX_W'(data_in), ADDR_W));
        end
    end

    // Byte arriving while the FIFO is full is parked until laf_state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                    full_byte <= '0;
        else if (ld_state && fifo_full) full_byte <= data_in;
    end

    // Registered data stream to the FIFOs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                     dout <= '0;
        else if (lfd_state)              dout <= hold_hdr;
        else if (ld_state && !fifo_full) dout <= data_in;
        else if (laf_state)              dout <= full_byte;
    end

    // End-of-packet flags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            low_pkt_valid <= 1'b0;
            parity_done   <= 1'b0;
        end else begin
            if (chk_load)         low_pkt_valid <= 1'b1;
            else if (rst_int_reg) low_pkt_valid <= 1'b0;

            if (detect_add)       parity_done <= 1'b0;
            else if (pd_set)      parity_done <= 1'b1;
        end
    end

    // One-shot check evaluation per packet and saturating bad-packet count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err     <= 1'b0;
            len_err <= 1'b0;
            checked <= 1'b0;
            err_cnt <= '0;
        end else if (hdr_valid) begin
            err     <= 1'b0;
            len_err <= 1'b0;
            checked <= 1'b0;
        end else if (parity_done && !checked) begin
            err     <= ~acc_match;
            len_err <= ~len_match;
            checked <= 1'b1;
            if ((!acc_match || !len_match) && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    router_chk_acc #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .CHK_MODE (CHK_MODE)
    ) u_chk_acc (
        .clk       (clock),
        .rst_n     (resetn),
        .clr       (hdr_valid),
        .fold_hdr  (lfd_state),
        .fold_pay  (pay_fold),
        .load_chk  (chk_load),
        .hold_hdr  (hold_hdr),
        .data_in   (data_in),
        .len_field (len_field),
        .acc_match (acc_match),
        .len_match (len_match)
    );

endmodule
